// File: rtl/ct_f_spsram_init.sv
// Single-port SRAM model with a self-initialising sweep.
// After reset release (or an INIT_REQ pulse) every location is written with
// INIT_VALUE, one per cycle, before external accesses are accepted.
// Read data is registered; an optional second stage adds one cycle of latency.
module ct_f_spsram_init #(
  parameter int unsigned           ADDR_WIDTH = 9,
  parameter int unsigned           DATA_WIDTH = 7,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}},
  parameter bit                    OUT_REG    = 1'b0,
  parameter bit                    RDW_MODE   = 1'b0
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  INIT_REQ,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_BUSY
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_holding_q, addr_holding_d;
  logic [DATA_WIDTH-1:0] q1_q, q1_d;
  logic [DATA_WIDTH-1:0] q2_q, q2_d;

  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] rd_old_s;
  logic [DATA_WIDTH-1:0] merged_s;

  // Old contents at the access address and the bit-masked write result.
  assign rd_old_s = mem_q[A];
  assign merged_s = (rd_old_s & WEN) | (D & ~WEN);

  // Next-state logic: init sweep, access handling and output pipeline.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_holding_d = addr_holding_q;
    q1_d           = q1_q;
    q2_d           = q2_q;
    mem_we_s       = 1'b0;
    mem_waddr_s    = cnt_q;
    mem_wdata_s    = INIT_VALUE;
    case (state_q)
      ST_INIT: begin
        // Array writes are suppressed while reset is held so the sweep
        // starts on the first edge after release.
        mem_we_s    = cpurst_b;
        mem_waddr_s = cnt_q;
        mem_wdata_s = INIT_VALUE;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = ADDR_ZERO;
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + ADDR_ONE;
        end
      end
      ST_READY: begin
        cnt_d = ADDR_ZERO;
        if (INIT_REQ) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_READY;
        end
        // An access in the same cycle as INIT_REQ is still carried out.
        if (!CEN) begin
          addr_holding_d = A;
          q2_d           = q1_q;
          if (!GWEN) begin
            mem_we_s    = cpurst_b;
            mem_waddr_s = A;
            mem_wdata_s = merged_s;
            if (RDW_MODE) begin
              q1_d = rd_old_s;
            end else begin
              q1_d = merged_s;
            end
          end else begin
            q1_d = rd_old_s;
          end
        end else begin
          q1_d = q1_q;
          q2_d = q2_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = ADDR_ZERO;
      end
    endcase
  end

  // Control and output registers; the array itself is never reset.
  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q        <= ST_INIT;
      cnt_q          <= ADDR_ZERO;
      addr_holding_q <= ADDR_ZERO;
      q1_q           <= {DATA_WIDTH{1'b0}};
      q2_q           <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_holding_q <= addr_holding_d;
      q1_q           <= q1_d;
      q2_q           <= q2_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign Q         = OUT_REG ? q2_q : q1_q;
  assign INIT_BUSY = (state_q == ST_INIT);

endmodule

// File: tb/tb_ct_f_spsram_init.sv
// Bench for ct_f_spsram_init: two instances (write-first/no output stage and
// read-first/output stage) share stimulus and are compared every cycle with a
// behavioural model, plus a table of hand-computed vectors and directed
// sequences for init length, INIT_REQ and mid-sweep reset.
module tb_ct_f_spsram_init;

  localparam int         DEPTH = 512;
  localparam logic [6:0] IV    = 7'h55;

  logic       CLK = 1'b0;
  logic       cpurst_b;
  logic [8:0] A;
  logic       CEN;
  logic       GWEN;
  logic [6:0] WEN;
  logic [6:0] D;
  logic       INIT_REQ;
  logic [6:0] q_a;
  logic [6:0] q_b;
  logic       busy_a;
  logic       busy_b;

  always #5 CLK = ~CLK;

  ct_f_spsram_init #(
    .ADDR_WIDTH(9), .DATA_WIDTH(7), .INIT_VALUE(7'h55), .OUT_REG(1'b0), .RDW_MODE(1'b0)
  ) u_dut_wf (
    .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .D(D), .INIT_REQ(INIT_REQ), .Q(q_a), .INIT_BUSY(busy_a)
  );

  ct_f_spsram_init #(
    .ADDR_WIDTH(9), .DATA_WIDTH(7), .INIT_VALUE(7'h55), .OUT_REG(1'b1), .RDW_MODE(1'b1)
  ) u_dut_rf (
    .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .D(D), .INIT_REQ(INIT_REQ), .Q(q_b), .INIT_BUSY(busy_b)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: memory image, busy flag, sweep position, output values.
  logic [6:0] mem_m [DEPTH];
  bit         busy_m;
  int         cnt_m;
  logic [6:0] qa_m;
  logic [6:0] qb1_m;
  logic [6:0] qb2_m;

  typedef struct {
    logic       cen;
    logic       gwen;
    logic [6:0] wen;
    logic [8:0] a;
    logic [6:0] d;
    logic [6:0] exp_qa;
    logic [6:0] exp_qb;
  } vec_t;

  vec_t vecs [11];

  function automatic void model_reset();
    busy_m = 1'b1;
    cnt_m  = 0;
    qa_m   = 7'h00;
    qb1_m  = 7'h00;
    qb2_m  = 7'h00;
  endfunction

  function automatic void model_edge();
    logic [6:0] old_v;
    logic [6:0] new_v;
    if (!cpurst_b) begin
      model_reset();
    end else if (busy_m) begin
      mem_m[cnt_m] = IV;
      cnt_m = cnt_m + 1;
      if (cnt_m == DEPTH) begin
        busy_m = 1'b0;
        cnt_m  = 0;
      end
    end else begin
      if (!CEN) begin
        old_v = mem_m[A];
        new_v = old_v;
        for (int b = 0; b < 7; b++) begin
          if (!GWEN && !WEN[b]) new_v[b] = D[b];
        end
        qa_m  = new_v;
        qb2_m = qb1_m;
        qb1_m = old_v;
        if (!GWEN) mem_m[A] = new_v;
      end
      if (INIT_REQ) busy_m = 1'b1;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("q_write_first", int'(q_a), int'(qa_m));
    check("q_read_first_reg", int'(q_b), int'(qb2_m));
    check("busy_wf", int'(busy_a), int'(busy_m));
    check("busy_rf", int'(busy_b), int'(busy_m));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    CEN      = 1'b1;
    GWEN     = 1'b1;
    WEN      = 7'h7F;
    INIT_REQ = 1'b0;
  endtask

  task automatic access(input logic gwen, input logic [8:0] a, input logic [6:0] d,
                        input logic [6:0] wen);
    CEN  = 1'b0;
    GWEN = gwen;
    A    = a;
    D    = d;
    WEN  = wen;
  endtask

  // Run until INIT_BUSY drops (bounded), optionally hammering random accesses.
  task automatic wait_init(input string name, input bit rnd);
    int n;
    n = 0;
    while (busy_a && n < 600) begin
      if (rnd) begin
        access(1'($urandom_range(0, 1)), 9'($urandom), 7'($urandom), 7'($urandom));
        CEN = 1'($urandom_range(0, 1));
      end else begin
        idle();
      end
      tick();
      n++;
    end
    idle();
    check(name, n, DEPTH);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 7'h7F, 9'h000, 7'h00, 7'h55, 7'h00};
    vecs[1]  = '{1'b0, 1'b1, 7'h7F, 9'h0FF, 7'h00, 7'h55, 7'h55};
    vecs[2]  = '{1'b0, 1'b1, 7'h7F, 9'h1FF, 7'h00, 7'h55, 7'h55};
    vecs[3]  = '{1'b0, 1'b0, 7'h00, 9'h010, 7'h7F, 7'h7F, 7'h55};
    vecs[4]  = '{1'b0, 1'b0, 7'h70, 9'h010, 7'h00, 7'h70, 7'h55};
    vecs[5]  = '{1'b0, 1'b1, 7'h7F, 9'h010, 7'h00, 7'h70, 7'h7F};
    vecs[6]  = '{1'b0, 1'b0, 7'h00, 9'h020, 7'h2A, 7'h2A, 7'h70};
    vecs[7]  = '{1'b0, 1'b1, 7'h7F, 9'h020, 7'h00, 7'h2A, 7'h55};
    vecs[8]  = '{1'b1, 1'b0, 7'h00, 9'h1FF, 7'h7F, 7'h2A, 7'h55};
    vecs[9]  = '{1'b0, 1'b1, 7'h7F, 9'h003, 7'h00, 7'h55, 7'h2A};
    vecs[10] = '{1'b0, 1'b1, 7'h7F, 9'h003, 7'h00, 7'h55, 7'h55};

    // Reset held: outputs cleared, busy asserted.
    idle();
    A        = 9'h000;
    D        = 7'h00;
    cpurst_b = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (3) tick();
    cpurst_b = 1'b1;
    wait_init("init_len_first", 1'b0);

    // Table of hand-computed vectors.
    for (int i = 0; i < 11; i++) begin
      access(vecs[i].gwen, vecs[i].a, vecs[i].d, vecs[i].wen);
      CEN = vecs[i].cen;
      tick();
      check($sformatf("vec%0d_qa", i), int'(q_a), int'(vecs[i].exp_qa));
      check($sformatf("vec%0d_qb", i), int'(q_b), int'(vecs[i].exp_qb));
    end

    // Deselected cycles with toggling inputs: Q holds, array untouched.
    for (int i = 0; i < 10; i++) begin
      access(1'b0, 9'($urandom), 7'($urandom), 7'h00);
      CEN = 1'b1;
      tick();
      check("hold_qa", int'(q_a), int'(7'h55));
    end
    access(1'b1, 9'h003, 7'h00, 7'h7F);
    tick();
    check("reread_003", int'(q_a), int'(7'h55));
    access(1'b1, 9'h1FF, 7'h00, 7'h7F);
    tick();
    check("reread_1ff", int'(q_a), int'(7'h55));

    // INIT_REQ with a coincident read; accesses during the sweep are ignored.
    access(1'b0, 9'h100, 7'h11, 7'h00);
    tick();
    access(1'b1, 9'h100, 7'h00, 7'h7F);
    INIT_REQ = 1'b1;
    tick();
    INIT_REQ = 1'b0;
    check("initreq_read", int'(q_a), int'(7'h11));
    check("initreq_busy", int'(busy_a), 1);
    wait_init("init_len_req", 1'b1);
    check("initreq_q_held", int'(q_a), int'(7'h11));
    access(1'b1, 9'h100, 7'h00, 7'h7F);
    tick();
    check("after_init_100", int'(q_a), int'(7'h55));

    // Random traffic against the model, with occasional re-init requests.
    for (int i = 0; i < 1500; i++) begin
      access(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 7'($urandom), 7'($urandom));
      CEN      = 1'($urandom_range(0, 1));
      INIT_REQ = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle();
    if (busy_a) wait_init("init_len_rand", 1'b0);

    // Reset when the sweep counter reaches 200, then a full rerun.
    INIT_REQ = 1'b1;
    tick();
    INIT_REQ = 1'b0;
    repeat (200) tick();
    cpurst_b = 1'b0;
    #1;
    model_reset();
    check("midinit_rst_qa", int'(q_a), 0);
    check("midinit_rst_qb", int'(q_b), 0);
    check("midinit_rst_busy", int'(busy_a), 1);
    repeat (2) tick();
    cpurst_b = 1'b1;
    wait_init("init_len_rerun", 1'b0);
    for (int i = 0; i < 3; i++) begin
      access(1'b1, (i == 0) ? 9'h000 : ((i == 1) ? 9'h0C8 : 9'h1FF), 7'h00, 7'h7F);
      tick();
      check("rerun_read", int'(q_a), int'(7'h55));
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
